multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle control FSM for the RV32I-subset core. Sequences fetch/decode/execute/mem/writeback,
//  drives the immediate-mux select (imm_sel) and datapath enables, and handshakes with the
//  instruction/data memory port. Sits between the IR opcode field and the datapath.
// PARAMETERS
//  TMO_W      8   width of memory-wait counter; timeout after 2**TMO_W-1 cycles without mem_ready
// PORTS
//  clk           in   1  core clock, rising edge
//  reset_n       in   1  asynchronous, active-low reset
//  opcode        in   7  IR[6:0], valid from the cycle after ir_load
//  branch_taken  in   1  branch compare result from ALU, valid in EXEC
//  mem_ready     in   1  memory completes the current request this cycle
//  mem_req       out  1  memory request, held until mem_ready sampled high
//  mem_we        out  1  1 = store, 0 = read (fetch/load)
//  mem_is_fetch  out  1  address mux: 1 = PC, 0 = ALU result
//  ir_load       out  1  capture instruction word into IR
//  imm_sel       out  2  00 R-type(zero), 01 I-type, 10 branch, 11 S-type
//  alu_src_imm   out  1  ALU operand B = immediate
//  reg_write     out  1  register-file write enable
//  wb_sel        out  1  writeback source: 0 = ALU, 1 = memory data
//  pc_write      out  1  PC update strobe
//  pc_src        out  1  0 = PC+4, 1 = PC+imm
//  instr_retired out  1  one-cycle pulse per completed instruction
//  mem_timeout   out  1  sticky: a memory wait exceeded the limit
//  illegal       out  1  sticky illegal-opcode flag (0 when ILLEGAL_TRAP_EN is not defined)
// BEHAVIOUR
//  - Reset: state=FETCH, all outputs 0, imm_sel=00, wait counter 0. mem_req rises the first cycle after release.
//  - States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Outputs are registered, Moore-style.
//  - FETCH: mem_req=1, mem_is_fetch=1, mem_we=0. On mem_ready: ir_load=1 pulse -> DECODE.
//  - DECODE (1 cycle): classify opcode. 0110011 R (imm_sel 00), 0010011 I-ALU (01), 0000011 LOAD (01),
//    0100011 STORE (11), 1100011 BRANCH (10). imm_sel is registered here and held until the next DECODE.
//  - EXEC (1 cycle): alu_src_imm=1 for all classes except R. R/I -> WB; LOAD/STORE -> MEM;
//    BRANCH: pc_write=1, pc_src=branch_taken, instr_retired=1 -> FETCH.
//  - MEM: mem_req=1, mem_is_fetch=0, mem_we=1 for STORE only. On mem_ready: LOAD -> WB;
//    STORE: pc_write=1, pc_src=0, instr_retired=1 -> FETCH.
//  - WB (1 cycle): reg_write=1, wb_sel=1 for LOAD, else 0; pc_write=1, pc_src=0, instr_retired=1 -> FETCH.
//  - Latency excluding memory wait: R/I 4 cycles, LOAD 5, STORE 4, BRANCH 3.
//  - mem_ready is ignored when mem_req=0. mem_req/addr/we are stable while waiting.
//  - Wait counter: clears on entry to FETCH/MEM, increments each cycle without mem_ready, saturates.
//    At 2**TMO_W-1, mem_timeout sets (sticky); the FSM keeps waiting and does not abort.
//  - Reset during any state, including a pending request: async return to FETCH; mem_req drops immediately.
//  - pc_write and ir_load never assert in the same cycle.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: an unlisted opcode in DECODE -> TRAP. TRAP sets illegal=1, asserts no
//    strobes, has no exit, and is left only by reset.
//  ILLEGAL_TRAP_EN not defined: an unlisted opcode executes as a NOP. Sequence DECODE -> EXEC -> WB with
//    reg_write=0; pc_write=1, pc_src=0, instr_retired=1 in WB. illegal is tied to 0.
// STRUCTURE
//  Shared package cpu_ctrl_pkg: state encoding, IMM_R/IMM_I/IMM_B/IMM_S codes, OP_* opcode constants,
//    instruction-class enum.
//  Sub-module ctrl_opcode_decode: combinational opcode -> {class, imm_sel, legal}; reused by the verification model.
// TESTING
//  1 ADD (0110011), mem_ready tied 1 -> imm_sel=00, reg_write in cycle 4, retire pulse, pc_src=0.
//  2 LW (0000011), data mem_ready delayed 3 cycles -> mem_req held 4 cycles, mem_we=0, wb_sel=1, total 8 cycles.
//  3 SW (0100011) -> imm_sel=11, mem_we=1 in MEM, reg_write never asserts, retire on mem_ready.
//  4 BEQ (1100011) with branch_taken=1, then =0 -> imm_sel=10; pc_src=1, then 0; 3 cycles each.
//  5 Opcode 1111111 -> with ILLEGAL_TRAP_EN: illegal=1, FSM frozen; without it: NOP retire, PC+4.
//  6 TMO_W=3, mem_ready held 0 for 10 cycles -> mem_timeout=1 at wait 7; reset_n pulse mid-MEM -> FETCH, outputs 0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle control path: FSM state encoding,
// immediate-select codes, RV32I opcode constants and the instruction class.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  localparam logic [1:0] IMM_R = 2'b00;
  localparam logic [1:0] IMM_I = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_S = 2'b11;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    CLS_R      = 3'd0,
    CLS_I      = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_NOP    = 3'd5
  } instr_class_t;

endpackage

// File: rtl/ctrl_opcode_decode.sv
// Combinational opcode classifier: opcode -> {class, imm_sel, legal}.
// Unlisted opcodes come out as CLS_NOP with legal=0 and the R-type (zero) immediate.
module ctrl_opcode_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [6:0]   opcode,
  output instr_class_t cls,
  output logic [1:0]   imm_sel,
  output logic         legal
);

  // Table lookup on the major opcode.
  always_comb begin
    cls     = CLS_NOP;
    imm_sel = IMM_R;
    legal   = 1'b0;
    case (opcode)
      OP_R:      begin cls = CLS_R;      imm_sel = IMM_R; legal = 1'b1; end
      OP_IMM:    begin cls = CLS_I;      imm_sel = IMM_I; legal = 1'b1; end
      OP_LOAD:   begin cls = CLS_LOAD;   imm_sel = IMM_I; legal = 1'b1; end
      OP_STORE:  begin cls = CLS_STORE;  imm_sel = IMM_S; legal = 1'b1; end
      OP_BRANCH: begin cls = CLS_BRANCH; imm_sel = IMM_B; legal = 1'b1; end
      default:   begin cls = CLS_NOP;    imm_sel = IMM_R; legal = 1'b0; end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH.
// Optional feature macro: ILLEGAL_TRAP_EN (unlisted opcode locks the FSM in TRAP
// until reset; without it such opcodes retire as a NOP).
//
// Memory handshake: mem_req is a registered request that stays high, with
// mem_we and mem_is_fetch unchanged, until a cycle in which mem_ready is high;
// that cycle completes the transfer and mem_req drops (or re-arms for the next
// fetch) on the following edge. mem_ready is don't-care while mem_req is low.
//
// State-dependent outputs are registered on entry to each state. The completion
// strobes (ir_load, pc_write, pc_src, instr_retired) are decoded from the
// registered state and qualified by mem_ready / branch_taken, because they must
// land in the same cycle the memory returns data or the branch compare is valid.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int TMO_W = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_is_fetch,
  output logic       ir_load,
  output logic [1:0] imm_sel,
  output logic       alu_src_imm,
  output logic       reg_write,
  output logic       wb_sel,
  output logic       pc_write,
  output logic       pc_src,
  output logic       instr_retired,
  output logic       mem_timeout,
  output logic       illegal,
  output state_t     dbg_state
);

  localparam logic [TMO_W-1:0] WAIT_MAX = '1;

  state_t            state;
  instr_class_t      cls_q;
  logic [TMO_W-1:0]  wait_cnt;

  instr_class_t      dec_cls;
  logic [1:0]        dec_imm_sel;
  logic              dec_legal;

  logic              fetch_done;
  logic              mem_done;
  logic              exec_branch;
  logic              waiting;

  ctrl_opcode_decode u_decode (
    .opcode  (opcode),
    .cls     (dec_cls),
    .imm_sel (dec_imm_sel),
    .legal   (dec_legal)
  );

  assign fetch_done  = (state == ST_FETCH) && mem_req && mem_ready;
  assign mem_done    = (state == ST_MEM) && mem_req && mem_ready;
  assign exec_branch = (state == ST_EXEC) && (cls_q == CLS_BRANCH);
  assign waiting     = ((state == ST_FETCH) || (state == ST_MEM)) && mem_req && !mem_ready;

  // Completion strobes; ir_load lives only in FETCH and pc_write never does.
  assign ir_load       = fetch_done;
  assign pc_write      = exec_branch || (mem_done && (cls_q == CLS_STORE)) || (state == ST_WB);
  assign pc_src        = exec_branch && branch_taken;
  assign instr_retired = pc_write;

  assign dbg_state = state;

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
  assign illegal = illegal_q;
`else
  logic unused_legal;
  assign unused_legal = dec_legal;
  assign illegal      = 1'b0;
`endif

  // Control FSM with registered outputs and the memory-wait watchdog.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_FETCH;
      cls_q        <= CLS_R;
      wait_cnt     <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_is_fetch <= 1'b0;
      imm_sel      <= IMM_R;
      alu_src_imm  <= 1'b0;
      reg_write    <= 1'b0;
      wb_sel       <= 1'b0;
      mem_timeout  <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q    <= 1'b0;
`endif
    end else begin
      // Saturating wait count; the FSM keeps waiting after the flag sets.
      if (waiting) begin
        if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
        if (wait_cnt == WAIT_MAX - 1'b1) mem_timeout <= 1'b1;
      end

      case (state)
        ST_FETCH: begin
          if (!mem_req) begin
            // First cycle out of reset: raise the fetch request.
            mem_req      <= 1'b1;
            mem_is_fetch <= 1'b1;
            mem_we       <= 1'b0;
            wait_cnt     <= '0;
          end else if (mem_ready) begin
            mem_req      <= 1'b0;
            mem_is_fetch <= 1'b0;
            state        <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          cls_q   <= dec_cls;
          imm_sel <= dec_imm_sel;
`ifdef ILLEGAL_TRAP_EN
          if (!dec_legal) begin
            illegal_q <= 1'b1;
            state     <= ST_TRAP;
          end else begin
            alu_src_imm <= (dec_cls != CLS_R);
            state       <= ST_EXEC;
          end
`else
          alu_src_imm <= (dec_cls != CLS_R);
          state       <= ST_EXEC;
`endif
        end

        ST_EXEC: begin
          alu_src_imm <= 1'b0;
          case (cls_q)
            CLS_LOAD, CLS_STORE: begin
              mem_req      <= 1'b1;
              mem_we       <= (cls_q == CLS_STORE);
              mem_is_fetch <= 1'b0;
              wait_cnt     <= '0;
              state        <= ST_MEM;
            end
            CLS_BRANCH: begin
              mem_req      <= 1'b1;
              mem_is_fetch <= 1'b1;
              mem_we       <= 1'b0;
              wait_cnt     <= '0;
              state        <= ST_FETCH;
            end
            default: begin
              // R, I and NOP go through WB; NOP leaves the register file alone.
              reg_write <= (cls_q != CLS_NOP);
              wb_sel    <= 1'b0;
              state     <= ST_WB;
            end
          endcase
        end

        ST_MEM: begin
          if (mem_done) begin
            mem_we <= 1'b0;
            if (cls_q == CLS_LOAD) begin
              mem_req   <= 1'b0;
              reg_write <= 1'b1;
              wb_sel    <= 1'b1;
              state     <= ST_WB;
            end else begin
              mem_req      <= 1'b1;
              mem_is_fetch <= 1'b1;
              wait_cnt     <= '0;
              state        <= ST_FETCH;
            end
          end
        end

        ST_WB: begin
          reg_write    <= 1'b0;
          wb_sel       <= 1'b0;
          mem_req      <= 1'b1;
          mem_is_fetch <= 1'b1;
          mem_we       <= 1'b0;
          wait_cnt     <= '0;
          state        <= ST_FETCH;
        end

        ST_TRAP: begin
          // Terminal: only reset leaves this state.
        end

        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule
